// File: rtl/coherence_pkg.sv
// Shared encodings for the directory coherence protocol: line states, message
// codes on both directions of the node/directory link, and node controller states.
package coherence_pkg;

  typedef enum logic [1:0] {
    LS_INVALID   = 2'b00,
    LS_EXCLUSIVE = 2'b01,
    LS_SHARED    = 2'b10
  } line_state_e;

  // The directory calls an unowned block UNCACHED; same code as INVALID.
  localparam line_state_e LS_UNCACHED = LS_INVALID;

  typedef enum logic [1:0] {
    MSG_READ_MISS  = 2'd0,
    MSG_WRITE_MISS = 2'd1,
    MSG_WRITE_BACK = 2'd2,
    MSG_DATA_WB    = 2'd3
  } msg_type_e;

  typedef enum logic [1:0] {
    DIR_FETCH            = 2'd0,
    DIR_INVALIDATE       = 2'd1,
    DIR_FETCH_INVALIDATE = 2'd2,
    DIR_DATA_REPLY       = 2'd3
  } dir_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVICT,
    ST_SEND_MISS,
    ST_WAIT_REPLY,
    ST_SERVE,
    ST_RESPOND
  } ctrl_state_e;

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped tag/state/data storage: one combinational read port and one
// synchronous write port; reset clears every line to INVALID with zero tag/data.
module cache_line_array
  import coherence_pkg::*;
#(
  parameter int LINES  = 4,
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [TAG_W-1:0]  rd_tag_o,
  output line_state_e       rd_state_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  line_state_e       wr_state_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [LINES-1:0][TAG_W-1:0]  tag_q;
  logic [LINES-1:0][1:0]        state_q;
  logic [LINES-1:0][DATA_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_q   <= '0;
      state_q <= '0;
      data_q  <= '0;
    end else if (we_i) begin
      tag_q[wr_idx_i]   <= wr_tag_i;
      state_q[wr_idx_i] <= wr_state_i;
      data_q[wr_idx_i]  <= wr_data_i;
    end
  end

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_state_o = line_state_e'(state_q[rd_idx_i]);
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/fsm_cache_node_controller.sv
// Cache-side end of the directory protocol: turns CPU loads/stores into miss and
// write-back messages and services FETCH/INVALIDATE/DATA_REPLY from the home node.
module fsm_cache_node_controller
  import coherence_pkg::*;
#(
  parameter int NODE_ID   = 0,
  parameter int NUM_NODES = 8,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int LINES     = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cpu_req_valid_i,
  input  logic                 cpu_req_write_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [DATA_W-1:0]    cpu_wdata_i,
  output logic                 cpu_ready_o,
  output logic                 cpu_done_o,
  output logic [DATA_W-1:0]    cpu_rdata_o,
  output logic                 msg_valid_o,
  output logic [1:0]           msg_type_o,
  output logic [ADDR_W-1:0]    msg_addr_o,
  output logic [DATA_W-1:0]    msg_data_o,
  output logic [NUM_NODES-1:0] msg_requester_o,
  input  logic                 msg_ready_i,
  input  logic                 dir_valid_i,
  input  logic [1:0]           dir_type_i,
  input  logic [ADDR_W-1:0]    dir_addr_i,
  input  logic [DATA_W-1:0]    dir_data_i,
  output logic                 dir_ready_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [NUM_NODES-1:0] REQ_ONEHOT = NUM_NODES'(1) << NODE_ID;

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              req_write_q, req_write_d;
  logic              srv_inv_q, srv_inv_d;

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;
  line_state_e       rd_state, wr_state;
  logic [DATA_W-1:0] rd_data, wr_data;
  logic              we;

  dir_type_e        dir_t;
  logic [IDX_W-1:0] cpu_idx, dir_idx, req_idx;
  logic [TAG_W-1:0] cpu_tag, dir_tag, req_tag;
  logic             cpu_hit, dir_match;

  assign dir_t   = dir_type_e'(dir_type_i);
  assign cpu_idx = cpu_addr_i[IDX_W-1:0];
  assign cpu_tag = cpu_addr_i[ADDR_W-1:IDX_W];
  assign dir_idx = dir_addr_i[IDX_W-1:0];
  assign dir_tag = dir_addr_i[ADDR_W-1:IDX_W];
  assign req_idx = req_addr_q[IDX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:IDX_W];

  cache_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W)
  ) u_lines (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .rd_idx_i  (rd_idx),
    .rd_tag_o  (rd_tag),
    .rd_state_o(rd_state),
    .rd_data_o (rd_data),
    .we_i      (we),
    .wr_idx_i  (wr_idx),
    .wr_tag_i  (wr_tag),
    .wr_state_i(wr_state),
    .wr_data_i (wr_data)
  );

  // The single read port follows whichever message is being examined this cycle.
  always_comb begin
    rd_idx = req_idx;
    if (state_q == ST_IDLE)
      rd_idx = dir_valid_i ? dir_idx : cpu_idx;
    else if (state_q == ST_WAIT_REPLY && dir_valid_i && dir_t == DIR_INVALIDATE)
      rd_idx = dir_idx;
  end

  assign cpu_hit   = (rd_state != LS_INVALID) && (rd_tag == cpu_tag);
  assign dir_match = (rd_state != LS_INVALID) && (rd_tag == dir_tag);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      srv_inv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_write_q <= req_write_d;
      srv_inv_q   <= srv_inv_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_addr_d      = req_addr_q;
    req_wdata_d     = req_wdata_q;
    req_write_d     = req_write_q;
    srv_inv_d       = srv_inv_q;
    we              = 1'b0;
    wr_idx          = rd_idx;
    wr_tag          = rd_tag;
    wr_state        = rd_state;
    wr_data         = rd_data;
    cpu_ready_o     = 1'b0;
    cpu_done_o      = 1'b0;
    cpu_rdata_o     = '0;
    msg_valid_o     = 1'b0;
    msg_type_o      = '0;
    msg_addr_o      = '0;
    msg_data_o      = '0;
    msg_requester_o = '0;
    dir_ready_o     = 1'b0;

    // Outputs are held quiet while reset is asserted so nothing handshakes.
    if (!reset_i) begin
      case (state_q)
        ST_IDLE: begin
          if (dir_valid_i) begin
            dir_ready_o = 1'b1;
            if (dir_t == DIR_INVALIDATE && dir_match && rd_state == LS_SHARED) begin
              we       = 1'b1;
              wr_state = LS_INVALID;
            end else if ((dir_t == DIR_FETCH || dir_t == DIR_FETCH_INVALIDATE) &&
                         dir_match && rd_state == LS_EXCLUSIVE) begin
              req_addr_d = dir_addr_i;
              srv_inv_d  = (dir_t == DIR_FETCH_INVALIDATE);
              state_d    = ST_SERVE;
            end
          end else begin
            cpu_ready_o = 1'b1;
            if (cpu_req_valid_i) begin
              req_addr_d  = cpu_addr_i;
              req_wdata_d = cpu_wdata_i;
              req_write_d = cpu_req_write_i;
              if (cpu_hit) begin
                if (!cpu_req_write_i) begin
                  state_d = ST_RESPOND;
                end else if (rd_state == LS_EXCLUSIVE) begin
                  we      = 1'b1;
                  wr_data = cpu_wdata_i;
                  state_d = ST_RESPOND;
                end else begin
                  state_d = ST_SEND_MISS;
                end
              end else begin
                state_d = (rd_state == LS_EXCLUSIVE) ? ST_EVICT : ST_SEND_MISS;
              end
            end
          end
        end

        ST_EVICT: begin
          msg_valid_o     = 1'b1;
          msg_type_o      = MSG_WRITE_BACK;
          msg_addr_o      = {rd_tag, req_idx};
          msg_data_o      = rd_data;
          msg_requester_o = REQ_ONEHOT;
          if (msg_ready_i) begin
            we       = 1'b1;
            wr_state = LS_INVALID;
            state_d  = ST_SEND_MISS;
          end
        end

        ST_SEND_MISS: begin
          msg_valid_o     = 1'b1;
          msg_type_o      = req_write_q ? MSG_WRITE_MISS : MSG_READ_MISS;
          msg_addr_o      = req_addr_q;
          msg_requester_o = REQ_ONEHOT;
          if (msg_ready_i) state_d = ST_WAIT_REPLY;
        end

        ST_WAIT_REPLY: begin
          // FETCH and FETCH_INVALIDATE stay parked on the link until IDLE.
          if (dir_valid_i && dir_t == DIR_INVALIDATE) begin
            dir_ready_o = 1'b1;
            if (dir_match && rd_state == LS_SHARED) begin
              we       = 1'b1;
              wr_state = LS_INVALID;
            end
          end else if (dir_valid_i && dir_t == DIR_DATA_REPLY) begin
            dir_ready_o = 1'b1;
            if (dir_addr_i == req_addr_q) begin
              we       = 1'b1;
              wr_idx   = req_idx;
              wr_tag   = req_tag;
              wr_state = req_write_q ? LS_EXCLUSIVE : LS_SHARED;
              wr_data  = req_write_q ? req_wdata_q : dir_data_i;
              state_d  = ST_RESPOND;
            end
          end
        end

        ST_SERVE: begin
          msg_valid_o     = 1'b1;
          msg_type_o      = MSG_DATA_WB;
          msg_addr_o      = req_addr_q;
          msg_data_o      = rd_data;
          msg_requester_o = REQ_ONEHOT;
          if (msg_ready_i) begin
            we       = 1'b1;
            wr_state = srv_inv_q ? LS_INVALID : LS_SHARED;
            state_d  = ST_IDLE;
          end
        end

        ST_RESPOND: begin
          cpu_done_o  = 1'b1;
          cpu_rdata_o = rd_data;
          state_d     = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
